// File: rtl/slave_read.sv
// AHB-Lite slave read path: status, nonce/destination readback and
// ciphertext FIFO reads. Wait states are inserted while the FIFO is empty,
// and illegal accesses get a two-cycle ERROR response.
module slave_read #(
  parameter int MAX_WAIT = 16
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         HSELx,
  input  logic [31:0]  HADDR,
  input  logic         HWRITE,
  input  logic [1:0]   HTRANS,
  input  logic [2:0]   HBURST,
  input  logic [2:0]   HSIZE,
  input  logic         HREADY,
  input  logic [127:0] nonce,
  input  logic [127:0] destination,
  input  logic         core_busy,
  input  logic         fifo_empty,
  input  logic [127:0] fifo_rdata,
  output logic         fifo_pop,
  output logic [31:0]  HRDATA,
  output logic         HREADYOUT,
  output logic         HRESP
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_WORD    = 3'b010;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  // The stall cycle spent in DATA is the first of MAX_WAIT stalls, so the
  // counter only has to cover the remaining MAX_WAIT-1 cycles in WAIT.
  localparam logic [7:0] WAIT_LAST    = 8'(MAX_WAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

  // Registered decode of the accepted address phase.
  typedef struct packed {
    logic       status;
    logic       nonce;
    logic       dest;
    logic       fifo;
    logic [1:0] word;
  } dec_t;

  state_t state, state_nxt;
  dec_t   dec_d, dec_q;
  logic [7:0]  wait_cnt;
  logic        err_sticky, sticky_clr;
  logic        accept, addr_err;
  logic [11:0] a;
  state_t      addr_nxt;

  logic [3:0][31:0] nonce_w, dest_w, fifo_w;
  assign nonce_w = nonce;
  assign dest_w  = destination;
  assign fifo_w  = fifo_rdata;

  logic unused_haddr;
  assign unused_haddr = &{1'b0, HADDR[31:12]};

  assign a      = HADDR[11:0];
  assign accept = HSELx & HREADY & HTRANS[1] & ~HWRITE;

  // Address-phase decode and legality check.
  always_comb begin
    dec_d        = '0;
    dec_d.status = (a == 12'h000);
    dec_d.nonce  = (a[11:4] == 8'h10);
    dec_d.dest   = (a[11:4] == 8'h18);
    dec_d.fifo   = (a[11:4] == 8'h20);
    dec_d.word   = a[3:2];
    addr_err = (a[1:0] != 2'b00)
             | (HSIZE != SIZE_WORD)
             | ((HBURST != BURST_SINGLE) & (HBURST != BURST_INCR4))
             | ((HBURST == BURST_INCR4) & (HTRANS == TRANS_NONSEQ) & (a[3:0] != 4'h0))
             | ~(dec_d.status | dec_d.nonce | dec_d.dest | dec_d.fifo);
    addr_nxt = accept ? (addr_err ? S_ERR1 : S_DATA) : S_IDLE;
  end

  // Next state and bus outputs; HRDATA is only non-zero on a completing DATA beat.
  always_comb begin
    state_nxt  = state;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = '0;
    fifo_pop   = 1'b0;
    sticky_clr = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = addr_nxt;
      S_DATA: begin
        if (dec_q.fifo && fifo_empty) begin
          HREADYOUT = 1'b0;
          state_nxt = (MAX_WAIT <= 1) ? S_ERR1 : S_WAIT;
        end else begin
          if (dec_q.status)     HRDATA = {29'b0, err_sticky, core_busy, ~fifo_empty};
          else if (dec_q.nonce) HRDATA = nonce_w[dec_q.word];
          else if (dec_q.dest)  HRDATA = dest_w[dec_q.word];
          else if (dec_q.fifo)  HRDATA = fifo_w[dec_q.word];
          fifo_pop   = dec_q.fifo & (dec_q.word == 2'd3);
          sticky_clr = dec_q.status;
          state_nxt  = addr_nxt;
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (!fifo_empty)                       state_nxt = S_DATA;
        else if (wait_cnt + 8'd1 == WAIT_LAST) state_nxt = S_ERR1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        HRESP     = 1'b1;
        state_nxt = addr_nxt;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, data-phase decode and wait counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      dec_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) dec_q <= dec_d;
      // Counting only in WAIT means the counter is zero whenever WAIT is entered.
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  // Sticky error flag: entering ERR1 beats a coincident STATUS read clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                  err_sticky <= 1'b0;
    else if (state != S_ERR1 && state_nxt == S_ERR1) err_sticky <= 1'b1;
    else if (sticky_clr)                           err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_slave_read.sv
// Bench for slave_read: vector table plus hand-written wait/error/reset
// sequences, checked through an expected-response queue.
module tb_slave_read;

  logic         HCLK, HRESETn, HSELx, HWRITE, HREADY;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST, HSIZE;
  logic [127:0] nonce, destination, fifo_rdata;
  logic         core_busy, fifo_empty;
  logic         fifo_pop, HREADYOUT, HRESP;
  logic [31:0]  HRDATA;

  slave_read #(.MAX_WAIT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
    .HREADY(HREADY), .nonce(nonce), .destination(destination),
    .core_busy(core_busy), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_pop(fifo_pop), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  // Single-slave system: bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [11:0] a;
    logic [2:0]  sz;
    logic [2:0]  bu;
    logic [1:0]  tr;
    logic [31:0] d;
    logic        er;
    logic        pp;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] d;
    logic        er;
    logic        pp;
    int          wt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tag   = 0;
  logic dph   = 1'b0;

  localparam logic [2:0] W = 3'b010, SGL = 3'b000, INC4 = 3'b011;
  localparam logic [1:0] NS = 2'b10, SQ = 2'b11;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic idle();
    HSELx  = 1'b0;
    HWRITE = 1'b0;
    HTRANS = 2'b00;
  endtask

  // Drive an address phase, queue its expected response, return after the accepting edge.
  task automatic issue(input logic [11:0] a, input logic [2:0] sz, input logic [2:0] bu,
                       input logic [1:0] tr, input logic [31:0] d, input logic er,
                       input logic pp, input int wt, input logic push);
    exp_t e;
    int   n;
    HSELx  = 1'b1;
    HWRITE = 1'b0;
    HADDR  = 32'h4000_0000 | {20'h0, a};
    HSIZE  = sz;
    HBURST = bu;
    HTRANS = tr;
    if (push) begin
      e.id = tag; e.d = d; e.er = er; e.pp = pp; e.wt = wt;
      tag++;
      sb.push_back(e);
    end
    n = 0;
    @(negedge HCLK);
    while (!HREADY && n < 300) begin
      @(negedge HCLK);
      n++;
    end
    if (!HREADY) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout addr=%h: HREADY stuck at %b want 1", a, HREADY);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || dph) && n < 300) begin
      @(negedge HCLK);
      n++;
    end
    if (sb.size() != 0 || dph) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb.size());
    end
    @(posedge HCLK); #1;
  endtask

  // Monitor: tracks the data phase from bus activity and checks each completion.
  initial begin
    exp_t e;
    int   stalls, e1;
    stalls = 0; e1 = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dph = 1'b0; stalls = 0; e1 = 0;
      end else begin
        if (dph && !HREADYOUT) begin
          if (HRESP) e1++; else stalls++;
        end else if (dph && HREADYOUT) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_resp: got data=%h resp=%b, want no response", HRDATA, HRESP);
          end else begin
            e = sb.pop_front();
            if (HRDATA !== e.d || HRESP !== e.er || fifo_pop !== e.pp ||
                stalls != e.wt || e1 != (e.er ? 1 : 0)) begin
              n_err++;
              $display("FAIL resp#%0d: got data=%h resp=%b pop=%b waits=%0d err1=%0d want data=%h resp=%b pop=%b waits=%0d err1=%0d",
                       e.id, HRDATA, HRESP, fifo_pop, stalls, e1,
                       e.d, e.er, e.pp, e.wt, e.er ? 1 : 0);
            end
          end
          stalls = 0; e1 = 0;
        end
        if (!(dph && HREADYOUT)) begin
          n_cmp++;
          if (fifo_pop !== 1'b0) begin
            n_err++;
            $display("FAIL stray_pop: got fifo_pop=%b want 0", fifo_pop);
          end
        end
        if (HREADY) dph = HSELx & HTRANS[1] & ~HWRITE;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{12'h000, W, SGL,  NS, 32'h0000_0003, 1'b0, 1'b0};
    tbl[1]  = '{12'h100, W, INC4, NS, 32'h0302_0100, 1'b0, 1'b0};
    tbl[2]  = '{12'h104, W, INC4, SQ, 32'h0706_0504, 1'b0, 1'b0};
    tbl[3]  = '{12'h108, W, INC4, SQ, 32'h0B0A_0908, 1'b0, 1'b0};
    tbl[4]  = '{12'h10C, W, INC4, SQ, 32'h0F0E_0D0C, 1'b0, 1'b0};
    tbl[5]  = '{12'h188, W, SGL,  NS, 32'hDDDD_0002, 1'b0, 1'b0};
    tbl[6]  = '{12'h204, W, SGL,  NS, 32'hCAFE_0001, 1'b0, 1'b0};
    tbl[7]  = '{12'h20C, W, SGL,  NS, 32'hCAFE_0003, 1'b0, 1'b1};
    tbl[8]  = '{12'h080, W, SGL,  NS, 32'h0,         1'b1, 1'b0};
    tbl[9]  = '{12'h000, 3'b000, SGL, NS, 32'h0,     1'b1, 1'b0};
    tbl[10] = '{12'h100, W, 3'b010, NS, 32'h0,       1'b1, 1'b0};
    tbl[11] = '{12'h102, W, SGL,  NS, 32'h0,         1'b1, 1'b0};
    tbl[12] = '{12'h104, W, INC4, NS, 32'h0,         1'b1, 1'b0};
    tbl[13] = '{12'h300, W, SGL,  NS, 32'h0,         1'b1, 1'b0};
    tbl[14] = '{12'h000, W, SGL,  NS, 32'h0000_0007, 1'b0, 1'b0};
    tbl[15] = '{12'h000, W, SGL,  NS, 32'h0000_0003, 1'b0, 1'b0};

    nonce       = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    destination = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    fifo_rdata  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    core_busy   = 1'b1;
    fifo_empty  = 1'b0;
    HADDR = '0; HSIZE = W; HBURST = SGL;
    idle();
    HRESETn = 1'b0;

    #3;
    chk("reset_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    chk("reset_hresp",     {31'b0, HRESP},     32'h0);
    chk("reset_hrdata",    HRDATA,             32'h0);
    chk("reset_pop",       {31'b0, fifo_pop},  32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Table: back-to-back transfers, including the INCR4 burst and error decodes.
    for (int i = 0; i < 16; i++)
      issue(tbl[i].a, tbl[i].sz, tbl[i].bu, tbl[i].tr, tbl[i].d, tbl[i].er, tbl[i].pp, 0, 1'b1);
    idle();
    drain();

    // Writes are ignored with a zero-wait OKAY, even to a read-illegal address.
    HSELx = 1'b1; HWRITE = 1'b1; HTRANS = NS; HADDR = 32'h080;
    @(posedge HCLK); #1;
    idle();
    chk("write_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    chk("write_hresp",     {31'b0, HRESP},     32'h0);
    @(posedge HCLK); #1;

    // Ciphertext read waiting on the FIFO: three stall cycles, then data with a pop.
    fifo_empty = 1'b1;
    issue(12'h20C, W, SGL, NS, 32'hCAFE_0003, 1'b0, 1'b1, 3, 1'b1);
    idle();
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    fifo_empty = 1'b0;
    drain();

    // FIFO stays empty: 16 stalls, ERROR, then STATUS shows and clears the sticky bit.
    fifo_empty = 1'b1;
    core_busy  = 1'b0;
    issue(12'h200, W, SGL, NS, 32'h0, 1'b1, 1'b0, 16, 1'b1);
    issue(12'h000, W, SGL, NS, 32'h4, 1'b0, 1'b0, 0, 1'b1);
    issue(12'h000, W, SGL, NS, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    idle();
    drain();

    // STATUS completing while an error is entered: the sticky bit stays set.
    fifo_empty = 1'b0;
    issue(12'h000, W, SGL, NS, 32'h1, 1'b0, 1'b0, 0, 1'b1);
    issue(12'h080, W, SGL, NS, 32'h0, 1'b1, 1'b0, 0, 1'b1);
    issue(12'h000, W, SGL, NS, 32'h5, 1'b0, 1'b0, 0, 1'b1);
    issue(12'h000, W, SGL, NS, 32'h1, 1'b0, 1'b0, 0, 1'b1);
    idle();
    drain();

    // Reset in the middle of WAIT (sticky bit set beforehand).
    issue(12'h080, W, SGL, NS, 32'h0, 1'b1, 1'b0, 0, 1'b1);
    idle();
    drain();
    fifo_empty = 1'b1;
    issue(12'h200, W, SGL, NS, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    idle();
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    chk("wait_stalled", {31'b0, HREADYOUT}, 32'h0);
    HRESETn = 1'b0;
    #1;
    chk("rst_wait_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    chk("rst_wait_hresp",     {31'b0, HRESP},     32'h0);
    chk("rst_wait_pop",       {31'b0, fifo_pop},  32'h0);
    chk("rst_wait_hrdata",    HRDATA,             32'h0);
    @(posedge HCLK); #1;
    HRESETn    = 1'b1;
    fifo_empty = 1'b0;
    @(posedge HCLK); #1;
    issue(12'h000, W, SGL, NS, 32'h1, 1'b0, 1'b0, 0, 1'b1);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
